delay_sched: RTL and testbench
==============================

# delay_sched

Round-robin scheduler that shares a single programmable delay counter among `NUM_REQ` requesters. Each requester hands over a delay value with a valid/ready handshake; the block counts that many clock cycles and then returns a one-cycle `done_o` pulse to the owner. It sits between the sequencing logic of several consumers (power-up staging, settle timers) and one counter resource. It replaces per-consumer fixed-count delay generators where one timer at a time is enough.

## Interface
- `NUM_REQ`, default 4: number of requesters, minimum 2.
- `DELAY_W`, default 8: width of each requested delay value.
- `clk_i`  in  1  sole clock; all state updates on rising edge.
- `arst_i`  in  1  asynchronous, active-high reset.
- `req_valid_i`  in  NUM_REQ  per-requester request valid.
- `req_delay_i`  in  NUM_REQ×DELAY_W  per-requester delay in cycles; sampled only at handshake.
- `req_ready_o`  out  NUM_REQ  one-hot-or-zero grant; high only for the selected requester while IDLE.
- `abort_i`  in  1  synchronous cancel of the running delay.
- `done_o`  out  NUM_REQ  one-cycle completion pulse to the owner of the finished delay.
- `busy_o`  out  1  high while in COUNT.
- `active_id_o`  out  $clog2(NUM_REQ)  id of the current/last owner.

## Operation
- FSM states: IDLE, COUNT.
- IDLE:
  - The arbiter picks the first requester with valid high, searching from `rr_ptr` upward with wrap-around.
  - `req_ready_o` is high for that requester only, combinationally from `req_valid_i` and `rr_ptr`.
  - Handshake means valid and ready both high at a rising edge. On handshake: `cnt <= req_delay_i[id]`, `active_id_o <= id`, `rr_ptr <= (id+1) mod NUM_REQ`, state goes to COUNT.
- COUNT:
  - `req_ready_o` is all zero.
  - If `abort_i` is high: go to IDLE with no `done_o`. Abort has priority over completion.
  - Else if `cnt == 0`: `done_o[active_id_o] <= 1` for one cycle, go to IDLE.
  - Else `cnt <= cnt - 1`.
- `done_o` is registered, and every bit clears at the next edge.
- `abort_i` is ignored in IDLE.
- A requester may drop valid before its handshake; no request is consumed.
- Delay 0 is legal. It behaves as the shortest delay (done after 1 edge).
- The counter never wraps: `cnt` is loaded with D and only decremented while non-zero.
- Reset: state IDLE, `cnt` 0, `rr_ptr` 0, `done_o` 0, `busy_o` 0, `active_id_o` 0. Reset during COUNT discards the delay and produces no `done_o`.

## Timing
- Handshake at edge k with delay D: `done_o` rises at edge k+D+1 and falls at edge k+D+2.
- `busy_o` is high from edge k to edge k+D+1.
- IDLE is re-entered at edge k+D+1, so a new handshake is possible at edge k+D+2 at the earliest. Throughput is one request per D+2 cycles.
- `req_ready_o` may be high in the same cycle that `done_o` is high.
- Abort sampled at edge a (a in k+1..k+D+1): IDLE from edge a; next handshake possible at edge a+1.
- All requesters valid continuously: grants rotate 0,1,2,3,0,…; no requester waits more than NUM_REQ-1 grants.

## Structure
- `delay_sched_pkg` holds:
  - the `state_e` enum (IDLE, COUNT);
  - the localparam helper for the id width, `$clog2(NUM_REQ)`.
- Sub-module `rr_arbiter`:
  - parameter `NUM_REQ`;
  - inputs `req`, `ptr`; outputs one-hot `gnt` and encoded `gnt_id`;
  - purely combinational.
- The top holds the FSM, the counter, `rr_ptr` and the `done_o` register.

## Test plan
- Reset, then requester 1 valid with D=5 and handshake at edge k → `done_o[1]` high only between edges k+6 and k+7; `busy_o` high for 6 cycles.
- All 4 valid continuously, D=2 each, from reset → grant order 0,1,2,3,0; handshakes 4 cycles apart; one `done_o` per grant to the matching bit.
- D=0 from requester 3 → `done_o[3]` exactly one cycle after the handshake edge; D=255 → done after 256 edges with no wrap.
- `abort_i` pulsed 3 cycles into D=10 → no `done_o`; `busy_o` low from the abort edge; the next pending requester is granted one cycle later.
- `arst_i` asserted mid-COUNT (asynchronous, between edges) → all outputs 0 immediately; after release, requester 0 has priority (`rr_ptr` = 0).
- `abort_i` and `cnt == 0` in the same cycle → no `done_o`, IDLE; valid dropped before handshake → no grant recorded and `rr_ptr` unchanged.

Source files
------------

// File: rtl/delay_sched_pkg.sv
// Shared types and helpers for the delay scheduler.
package delay_sched_pkg;

  // Scheduler FSM: waiting for a requester, or running the shared counter.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  localparam int DEFAULT_NUM_REQ = 4;
  localparam int DEFAULT_DELAY_W = 8;

  // Width of a requester id. Guarded so a degenerate count still yields a legal vector.
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/delay_sched_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, with wrap.
module rr_arbiter import delay_sched_pkg::*; #(
  parameter  int NUM_REQ = DEFAULT_NUM_REQ,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);

  int   idx;
  logic found;

  // Walk the requesters starting at ptr; the first valid one wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/delay_sched.sv
// Round-robin owner of one programmable delay counter shared by NUM_REQ requesters.
module delay_sched import delay_sched_pkg::*; #(
  parameter  int NUM_REQ = DEFAULT_NUM_REQ,
  parameter  int DELAY_W = DEFAULT_DELAY_W,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic                              clk_i,
  input  logic                              arst_i,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  input  logic [NUM_REQ-1:0][DELAY_W-1:0]   req_delay_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  input  logic                              abort_i,
  output logic [NUM_REQ-1:0]                done_o,
  output logic                              busy_o,
  output logic [ID_W-1:0]                   active_id_o
);

  state_e               state_q, state_d;
  logic [DELAY_W-1:0]   cnt_q,   cnt_d;
  logic [ID_W-1:0]      ptr_q,   ptr_d;
  logic [ID_W-1:0]      id_q,    id_d;
  logic [NUM_REQ-1:0]   done_q,  done_d;

  logic [NUM_REQ-1:0]   gnt;
  logic [ID_W-1:0]      gnt_id;
  logic                 hs;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req    (req_valid_i),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // Grant is only offered while the counter is free.
  assign req_ready_o = (state_q == IDLE) ? gnt : '0;
  assign hs          = |(req_valid_i & req_ready_o);

  assign busy_o      = (state_q == COUNT);
  assign done_o      = done_q;
  assign active_id_o = id_q;

  // Next-state: load on handshake, count down to zero, abort wins over completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    done_d  = '0;
    case (state_q)
      IDLE: begin
        if (hs) begin
          cnt_d   = req_delay_i[gnt_id];
          id_d    = gnt_id;
          ptr_d   = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + ID_W'(1);
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          done_d[id_q] = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q - DELAY_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any running delay without a completion pulse.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      id_q    <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_delay_sched.sv
// Directed bench for delay_sched: expected grants/completions are queued at stimulus
// time and a monitor thread pops and compares them as the DUT presents them.
module tb_delay_sched;

  localparam int N  = 4;
  localparam int DW = 8;

  typedef struct {
    int id;
    int cyc;
  } ev_t;

  logic              clk;
  logic              arst;
  logic [N-1:0]      valid;
  logic [N-1:0][DW-1:0] dly;
  logic [N-1:0]      ready;
  logic              abort;
  logic [N-1:0]      done;
  logic              busy;
  logic [1:0]        act_id;

  int  cyc;
  int  n_cmp;
  int  n_bad;
  ev_t gq[$];
  ev_t dq[$];

  delay_sched #(.NUM_REQ(N), .DELAY_W(DW)) dut (
    .clk_i       (clk),
    .arst_i      (arst),
    .req_valid_i (valid),
    .req_delay_i (dly),
    .req_ready_o (ready),
    .abort_i     (abort),
    .done_o      (done),
    .busy_o      (busy),
    .active_id_o (act_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic exp_g(input int id, input int c);
    ev_t e;
    e.id = id; e.cyc = c;
    gq.push_back(e);
  endtask

  task automatic exp_d(input int id, input int c);
    ev_t e;
    e.id = id; e.cyc = c;
    dq.push_back(e);
  endtask

  task automatic do_reset();
    arst  = 1'b1;
    valid = '0;
    abort = 1'b0;
    tick(2);
    arst = 1'b0;
    tick();
  endtask

  initial begin
    int c0, c1, nb;
    cyc   = 0;
    n_cmp = 0;
    n_bad = 0;
    arst  = 1'b1;
    valid = '0;
    dly   = '0;
    abort = 1'b0;

    fork
      // Monitor: handshakes (about to happen at the next edge) and done pulses.
      forever begin
        logic [N-1:0] hs;
        ev_t e;
        @(negedge clk); #3;
        hs = ready & valid;
        if (hs != '0) begin
          if (gq.size() == 0) check("unexpected_grant", longint'(hs), 0);
          else begin
            e = gq.pop_front();
            check("grant_vec", longint'(hs), longint'(1) << e.id);
            check("grant_cyc", cyc + 1, e.cyc);
          end
        end
        if (done != '0) begin
          if (dq.size() == 0) check("unexpected_done", longint'(done), 0);
          else begin
            e = dq.pop_front();
            check("done_vec", longint'(done), longint'(1) << e.id);
            check("done_cyc", cyc, e.cyc);
          end
        end
      end
      begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state, then requester 1 with D=5.
    do_reset();
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_id", act_id, 0);
    check("rst_ready", ready, 0);
    c0 = cyc;
    valid[1] = 1'b1; dly[1] = 8'd5;
    exp_g(1, c0 + 1); exp_d(1, c0 + 7);
    tick(); valid[1] = 1'b0;
    #1 check("t1_active_id", act_id, 1);
    nb = 0;
    for (int i = 0; i < 7; i++) begin
      #1 nb += int'(busy);
      tick();
    end
    check("t1_busy_cycles", nb, 6);

    // All valid, D=2, from reset: grants 0,1,2,3,0 four cycles apart.
    do_reset();
    c0 = cyc;
    valid = '1;
    for (int i = 0; i < N; i++) dly[i] = 8'd2;
    for (int j = 0; j < 5; j++) begin
      exp_g(j % N, c0 + 1 + 4*j);
      exp_d(j % N, c0 + 4 + 4*j);
    end
    tick(17); valid = '0;
    tick(5);

    // D=0 from requester 3, then D=255 (no wrap).
    c0 = cyc;
    valid[3] = 1'b1; dly[3] = 8'd0;
    exp_g(3, c0 + 1); exp_d(3, c0 + 2);
    tick(); valid[3] = 1'b0;
    tick(2);
    c0 = cyc;
    valid[3] = 1'b1; dly[3] = 8'd255;
    exp_g(3, c0 + 1); exp_d(3, c0 + 257);
    tick(); valid[3] = 1'b0;
    tick(255);
    #1 check("t3_busy_late", busy, 1);
    tick();
    #1 check("t3_busy_after", busy, 0);
    tick(2);

    // Abort 3 cycles into D=10; pending requester 2 granted one cycle later.
    c0 = cyc;
    valid[0] = 1'b1; dly[0] = 8'd10;
    valid[2] = 1'b1; dly[2] = 8'd1;
    exp_g(0, c0 + 1); exp_g(2, c0 + 5); exp_d(2, c0 + 7);
    tick(); valid[0] = 1'b0;
    tick(2); abort = 1'b1;
    tick(); abort = 1'b0;
    #1 check("t4_busy_abort", busy, 0);
    check("t4_ready", ready, 4'b0100);
    tick(); valid[2] = 1'b0;
    tick(4);

    // Asynchronous reset mid-count; afterwards requester 0 has priority.
    c0 = cyc;
    valid[2] = 1'b1; dly[2] = 8'd20;
    exp_g(2, c0 + 1);
    tick(); valid[2] = 1'b0;
    tick(4);
    #1 check("t5_id_pre", act_id, 2);
    #1 arst = 1'b1;
    #1;
    check("t5_busy_rst", busy, 0);
    check("t5_done_rst", done, 0);
    check("t5_id_rst", act_id, 0);
    tick(); #1 arst = 1'b0;
    tick();
    c1 = cyc;
    valid[0] = 1'b1; dly[0] = 8'd1;
    valid[1] = 1'b1; dly[1] = 8'd1;
    exp_g(0, c1 + 1); exp_d(0, c1 + 3);
    exp_g(1, c1 + 4); exp_d(1, c1 + 6);
    tick(); valid[0] = 1'b0;
    tick(3); valid[1] = 1'b0;
    tick(4);

    // Abort in the same cycle the count reaches zero: no done.
    c0 = cyc;
    valid[2] = 1'b1; dly[2] = 8'd2;
    exp_g(2, c0 + 1);
    tick(); valid[2] = 1'b0;
    tick(2); abort = 1'b1;
    tick(); abort = 1'b0;
    #1 check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    tick(3);

    // Valid dropped before its edge: no grant, pointer stays at 3.
    valid[3] = 1'b1; dly[3] = 8'd0;
    #1 check("t7_ready_glitch", ready, 4'b1000);
    #1 valid[3] = 1'b0;
    tick(2);
    c0 = cyc;
    valid[0] = 1'b1; dly[0] = 8'd0;
    valid[3] = 1'b1; dly[3] = 8'd0;
    exp_g(3, c0 + 1); exp_d(3, c0 + 2);
    exp_g(0, c0 + 3); exp_d(0, c0 + 4);
    tick(); valid[3] = 1'b0;
    tick(2); valid[0] = 1'b0;
    tick(4);

    check("grant_q_empty", gq.size(), 0);
    check("done_q_empty", dq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
